loadstore_wb_ctrl: RTL and testbench
====================================

LOADSTORE_WB_CTRL -- requirements
Module: loadstore_wb_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles spent in REQ+WAIT before fault.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op_valid  in  1  current instruction valid.
REQ-005 op_load  in  1  instruction is a load.
REQ-006 op_store  in  1  instruction is a store.
REQ-007 op_regwrite  in  1  instruction writes rd.
REQ-008 op_rd  in  5  destination register index.
REQ-009 mem_req  out  1  data-memory request valid.
REQ-010 mem_we  out  1  request is a write; valid only with mem_req.
REQ-011 mem_ready  in  1  memory accepts request this cycle.
REQ-012 mem_rvalid  in  1  read data valid this cycle.
REQ-013 mem_rdata  in  32  read data.
REQ-014 ld_data  out  32  registered load data feeding the writeback mux read-data input.
REQ-015 wb_sel  out  1  writeback mux select: 1 = ld_data, 0 = ALU result.
REQ-016 rf_we  out  1  register-file write enable.
REQ-017 rf_waddr  out  5  register-file write address.
REQ-018 stall  out  1  hold PC/instruction this cycle.
REQ-019 fault  out  1  sticky memory-timeout flag.
REQ-020 fault_clr  in  1  clears fault, leaves ERR.

Function
REQ-021 States SHALL be IDLE, REQ, WAIT, WB, ERR; one-hot or binary encoding is free.
REQ-022 IDLE, memory op (op_valid & (op_load|op_store)): stall=1 same cycle (Mealy); latch load flag, rd, regwrite; next REQ.
REQ-023 op_load & op_store both 1: SHALL be treated as load.
REQ-024 IDLE, op_valid, non-memory op: stall=0, wb_sel=0, rf_waddr=op_rd, rf_we=op_regwrite & (op_rd!=0), combinational; stay IDLE.
REQ-025 REQ: mem_req=1, mem_we=~latched load, stall=1; held until mem_ready=1; then load -> WAIT, store -> WB.
REQ-026 WAIT: stall=1; on mem_rvalid, ld_data <= mem_rdata, next WB.
REQ-027 WB: stall=0, wb_sel=1, rf_waddr=latched rd, rf_we = latched load & latched regwrite & (rd!=0); next IDLE; lasts exactly one cycle.
REQ-028 Timeout counter: cleared on IDLE->REQ, increments each REQ/WAIT cycle; on reaching TIMEOUT -> ERR, fault<=1.
REQ-029 mem_rvalid in the same cycle as timeout: rvalid wins, go WB, no fault.
REQ-030 ERR: stall=1, mem_req=0, rf_we=0; on fault_clr, fault<=0 and next IDLE (held instruction reissues).
REQ-031 mem_rvalid outside WAIT SHALL be ignored; ld_data unchanged.
REQ-032 op_* changes after IDLE->REQ SHALL be ignored until return to IDLE.
REQ-033 Load latency with mem_ready and mem_rvalid each on first opportunity: detect cycle 0, REQ cycle 1, WAIT cycle 2, rf_we cycle 3.
REQ-034 mem_req, mem_we, rf_we, stall outside the states listed SHALL be 0.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, counter=0, ld_data=0, fault=0, mem_req=0, mem_we=0, rf_we=0, wb_sel=0, rf_waddr=0, stall=0 regardless of clk.
REQ-036 Reset asserted mid-transaction SHALL abandon it; no rf_we after release until a new op is presented.

Verification
REQ-037 Load rd=5, mem_ready=1 at cycle 1, mem_rvalid=1 mem_rdata=0xDEADBEEF at cycle 2 -> cycle 3 rf_we=1, rf_waddr=5, wb_sel=1, ld_data=0xDEADBEEF, stall 1,1,1,0.
REQ-038 Store, mem_ready low 3 cycles then high -> mem_req=1 4 cycles, mem_we=1, then WB with rf_we=0, stall=0.
REQ-039 Load, mem_ready=1, no rvalid, TIMEOUT=16 -> fault=1, stall=1 held; fault_clr pulse -> fault=0, IDLE, op reissued.
REQ-040 ALU op rd=0 regwrite=1 -> rf_we=0, stall=0; rd=7 -> rf_we=1, wb_sel=0 same cycle.
REQ-041 rst_n low during WAIT -> all outputs 0 asynchronously; late mem_rvalid after release ignored.
REQ-042 Stray mem_rvalid in IDLE with data 0x1234 -> ld_data unchanged, no rf_we.

Source files
------------

// File: rtl/loadstore_wb_ctrl.sv
// Load/store controller: runs one data-memory transaction per memory instruction,
// stalls the front end while it is outstanding and drives register-file writeback.
module loadstore_wb_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic        op_regwrite,
  input  logic [4:0]  op_rd,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic        wb_sel,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        stall,
  output logic        fault,
  input  logic        fault_clr
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_ERR
  } state_t;

  state_t            state;
  logic              is_load;
  logic              regwrite_q;
  logic [RD_W-1:0]   rd_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              mem_op;
  logic              timed_out;

  assign mem_op    = op_valid & (op_load | op_store);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign timed_out = (cnt_inc >= CNT_W'(TIMEOUT));

  // Sequencing and latched instruction context; progress beats timeout on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      is_load    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      cnt        <= '0;
      ld_data    <= '0;
      fault      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            state      <= S_REQ;
            is_load    <= op_load;
            regwrite_q <= op_regwrite;
            rd_q       <= op_rd;
            cnt        <= '0;
          end
        end
        S_REQ: begin
          cnt <= cnt_inc;
          if (mem_ready) begin
            state <= is_load ? S_WAIT : S_WB;
          end else if (timed_out) begin
            state <= S_ERR;
            fault <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          if (mem_rvalid) begin
            ld_data <= mem_rdata;
            state   <= S_WB;
          end else if (timed_out) begin
            state <= S_ERR;
            fault <= 1'b1;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        S_ERR: begin
          if (fault_clr) begin
            fault <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode; IDLE terms are Mealy on the presented instruction and masked in reset.
  always_comb begin
    stall    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rf_waddr = '0;
    case (state)
      S_IDLE: begin
        if (rst_n && op_valid) begin
          if (op_load || op_store) begin
            stall = 1'b1;
          end else begin
            rf_waddr = op_rd;
            rf_we    = op_regwrite & (op_rd != '0);
          end
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        mem_we  = ~is_load;
        stall   = 1'b1;
      end
      S_WAIT: begin
        stall = 1'b1;
      end
      S_WB: begin
        wb_sel   = 1'b1;
        rf_waddr = rd_q;
        rf_we    = is_load & regwrite_q & (rd_q != '0);
      end
      S_ERR: begin
        stall = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_loadstore_wb_ctrl.sv
// Bench for loadstore_wb_ctrl: directed scenarios plus randomized memory/ALU traffic
// checked against a cycle-index model of the expected transaction timeline.
module tb_loadstore_wb_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_load, op_store, op_regwrite;
  logic [4:0]  op_rd;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_rdata, ld_data;
  logic        wb_sel, rf_we, stall, fault, fault_clr;
  logic [4:0]  rf_waddr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ld_model;

  loadstore_wb_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
    .op_regwrite(op_regwrite), .op_rd(op_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ld_data(ld_data),
    .wb_sel(wb_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .stall(stall), .fault(fault), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  // Control vector order: {stall, mem_req, mem_we, rf_we, wb_sel, fault}
  task automatic test_reset();
    rst_n = 1'b0;
    op_valid = 1'b1; op_load = 1'b0; op_store = 1'b0; op_regwrite = 1'b1; op_rd = 5'd7;
    #3;
    checks++;
    if ({stall, mem_req, mem_we, rf_we, wb_sel, fault} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", {stall, mem_req, mem_we, rf_we, wb_sel, fault}, 6'b0);
    end
    checks++;
    if (ld_data !== 32'h0 || rf_waddr !== 5'd0) begin
      errors++; $display("FAIL reset_data: got ld=%h waddr=%0d expected ld=0 waddr=0", ld_data, rf_waddr);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    ld_model = 32'h0;
  endtask

  // Present one memory instruction; memory answers after r ready-low cycles and v WAIT cycles.
  task automatic run_mem_op(input bit ld, input bit st, input bit rw, input logic [4:0] rd,
                            input int r, input int v, input logic [31:0] data, input string name);
    bit         is_ld;
    int         n_wb;
    bit         s_e, rq_e, we_e, rf_e, wb_e;
    logic [5:0] exp_ctl;
    is_ld = ld;
    n_wb  = is_ld ? r + v + 3 : r + 2;
    op_valid = 1'b1; op_load = ld; op_store = st; op_regwrite = rw; op_rd = rd;
    for (int k = 0; k <= n_wb; k++) begin
      if (k > 0) begin
        op_valid = 1'($urandom); op_load = 1'($urandom); op_store = 1'($urandom);
        op_regwrite = 1'($urandom); op_rd = 5'($urandom);
      end
      if (k >= 1 && k <= r) mem_ready = 1'b0;
      else if (k == r + 1)  mem_ready = 1'b1;
      else                  mem_ready = 1'($urandom);
      if (is_ld && k >= r + 2 && k < r + v + 2) begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end else if (is_ld && k == r + v + 2) begin
        mem_rvalid = 1'b1; mem_rdata = data;
      end else begin
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      end
      s_e  = (k < n_wb);
      rq_e = (k >= 1 && k <= r + 1);
      we_e = rq_e && !is_ld;
      wb_e = (k == n_wb);
      rf_e = wb_e && is_ld && rw && (rd != 5'd0);
      if (wb_e && is_ld) ld_model = data;
      exp_ctl = {s_e, rq_e, we_e, rf_e, wb_e, 1'b0};
      @(negedge clk);
      checks++;
      if ({stall, mem_req, mem_we, rf_we, wb_sel, fault} !== exp_ctl) begin
        errors++; $display("FAIL %s_ctl k=%0d: got %b expected %b", name, k,
                           {stall, mem_req, mem_we, rf_we, wb_sel, fault}, exp_ctl);
      end
      checks++;
      if (ld_data !== ld_model) begin
        errors++; $display("FAIL %s_ld_data k=%0d: got %h expected %h", name, k, ld_data, ld_model);
      end
      if (wb_e) begin
        checks++;
        if (rf_waddr !== rd) begin
          errors++; $display("FAIL %s_waddr: got %0d expected %0d", name, rf_waddr, rd);
        end
      end
      @(posedge clk); #1;
    end
    op_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_stray_rvalid();
    op_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({stall, mem_req, mem_we, rf_we, wb_sel, fault} !== 6'b0 || ld_data !== ld_model) begin
        errors++; $display("FAIL stray_rvalid k=%0d: got ctl=%b ld=%h expected ctl=000000 ld=%h",
                           k, {stall, mem_req, mem_we, rf_we, wb_sel, fault}, ld_data, ld_model);
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_alu(input int n);
    logic       rf_e;
    logic [5:0] exp_ctl;
    for (int i = 0; i < n; i++) begin
      op_load = 1'b0; op_store = 1'b0;
      if (i == 0)      begin op_valid = 1'b1; op_regwrite = 1'b1; op_rd = 5'd0; end
      else if (i == 1) begin op_valid = 1'b1; op_regwrite = 1'b1; op_rd = 5'd7; end
      else begin
        op_valid = ($urandom_range(0, 3) != 0); op_regwrite = 1'($urandom); op_rd = 5'($urandom);
      end
      mem_ready = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      rf_e = op_valid && op_regwrite && (op_rd != 5'd0);
      exp_ctl = {1'b0, 1'b0, 1'b0, rf_e, 1'b0, 1'b0};
      @(negedge clk);
      checks++;
      if ({stall, mem_req, mem_we, rf_we, wb_sel, fault} !== exp_ctl || ld_data !== ld_model) begin
        errors++; $display("FAIL alu i=%0d: got ctl=%b ld=%h expected ctl=%b ld=%h", i,
                           {stall, mem_req, mem_we, rf_we, wb_sel, fault}, ld_data, exp_ctl, ld_model);
      end
      if (rf_e) begin
        checks++;
        if (rf_waddr !== op_rd) begin
          errors++; $display("FAIL alu_waddr i=%0d: got %0d expected %0d", i, rf_waddr, op_rd);
        end
      end
      @(posedge clk); #1;
    end
    op_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Load accepted but never answered: fault after TO cycles in REQ+WAIT, then clear and reissue.
  task automatic test_timeout();
    logic [5:0] exp_ctl;
    op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_regwrite = 1'b1; op_rd = 5'd12;
    for (int k = 0; k <= int'(TO) + 3; k++) begin
      mem_ready = (k == 1);
      mem_rvalid = (k == 0 || k > int'(TO)) ? 1'($urandom) : 1'b0;
      mem_rdata = $urandom;
      exp_ctl = {1'b1, (k == 1), 1'b0, 1'b0, 1'b0, (k >= int'(TO) + 1)};
      @(negedge clk);
      checks++;
      if ({stall, mem_req, mem_we, rf_we, wb_sel, fault} !== exp_ctl || ld_data !== ld_model) begin
        errors++; $display("FAIL timeout k=%0d: got ctl=%b ld=%h expected ctl=%b ld=%h", k,
                           {stall, mem_req, mem_we, rf_we, wb_sel, fault}, ld_data, exp_ctl, ld_model);
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0; fault_clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall, fault} !== 2'b11) begin
      errors++; $display("FAIL fault_clr_hold: got stall/fault=%b expected 11", {stall, fault});
    end
    @(posedge clk); #1;
    fault_clr = 1'b0;
    run_mem_op(1'b1, 1'b0, 1'b1, 5'd12, 0, 0, 32'hA5A5_0F0F, "reissue");
  endtask

  task automatic test_reset_mid_wait();
    op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_regwrite = 1'b1; op_rd = 5'd9;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    ld_model = 32'h0;
    checks++;
    if ({stall, mem_req, mem_we, rf_we, wb_sel, fault} !== 6'b0 || ld_data !== 32'h0 || rf_waddr !== 5'd0) begin
      errors++; $display("FAIL reset_mid_wait: got ctl=%b ld=%h waddr=%0d expected all zero",
                         {stall, mem_req, mem_we, rf_we, wb_sel, fault}, ld_data, rf_waddr);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = $urandom | 32'h1;
      @(negedge clk);
      checks++;
      if ({stall, mem_req, mem_we, rf_we, wb_sel, fault} !== 6'b0 || ld_data !== ld_model) begin
        errors++; $display("FAIL late_rvalid k=%0d: got ctl=%b ld=%h expected ctl=000000 ld=%h", k,
                           {stall, mem_req, mem_we, rf_we, wb_sel, fault}, ld_data, ld_model);
      end
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_random(input int n);
    int kind;
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 3) test_alu(1 + int'($urandom_range(0, 2)));
      else run_mem_op(kind != 1, kind != 0, 1'($urandom), 5'($urandom),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom, "random");
    end
  endtask

  initial begin
    op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_regwrite = 1'b0; op_rd = 5'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; fault_clr = 1'b0;
    ld_model = 32'h0;
    test_reset();
    run_mem_op(1'b1, 1'b0, 1'b1, 5'd5, 0, 0, 32'hDEAD_BEEF, "load_basic");
    test_stray_rvalid();
    run_mem_op(1'b0, 1'b1, 1'b1, 5'd3, 3, 0, 32'h0, "store_wait");
    test_alu(8);
    run_mem_op(1'b1, 1'b1, 1'b1, 5'd17, 1, 2, 32'h1357_9BDF, "load_and_store");
    run_mem_op(1'b1, 1'b0, 1'b1, 5'd0, 0, 1, 32'h2468_ACE0, "load_rd0");
    test_timeout();
    run_mem_op(1'b1, 1'b0, 1'b1, 5'd21, 0, int'(TO) - 2, 32'hCAFE_F00D, "rvalid_at_timeout");
    test_random(40);
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
